// File: rtl/decoder_pkg.sv
// Shared decode definitions: RV32I/RV64I major opcodes, the 3-bit instruction
// type encoding presented on out_type, and the opcode -> type classifier.
package decoder_pkg;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

   typedef enum logic [2:0] {
      TYPE_R   = 3'b000,
      TYPE_I   = 3'b001,
      TYPE_S   = 3'b010,
      TYPE_B   = 3'b011,
      TYPE_U   = 3'b100,
      TYPE_J   = 3'b101,
      TYPE_INV = 3'b111
   } instr_type_e;

   // Map a major opcode to its instruction format. The word-sized RV64 opcodes
   // and the SYSTEM/MISC-MEM group are only legal when enabled by the caller;
   // compressed encodings (low bits != 11) are always illegal.
   function automatic instr_type_e classify(input logic [6:0] opc,
                                            input logic       rv64,
                                            input logic       sys_en);
      instr_type_e t;
      t = TYPE_INV;
      if (opc[1:0] == 2'b11) begin
         case (opc)
            OPC_OP:                         t = TYPE_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: t = TYPE_I;
            OPC_STORE:                      t = TYPE_S;
            OPC_BRANCH:                     t = TYPE_B;
            OPC_LUI, OPC_AUIPC:             t = TYPE_U;
            OPC_JAL:                        t = TYPE_J;
            OPC_OP_IMM_32:                  t = rv64   ? TYPE_I : TYPE_INV;
            OPC_OP_32:                      t = rv64   ? TYPE_R : TYPE_INV;
            OPC_SYSTEM, OPC_MISC_MEM:       t = sys_en ? TYPE_I : TYPE_INV;
            default:                        t = TYPE_INV;
         endcase
      end
      return t;
   endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational instruction decoder: raw 32-bit word -> format type,
// sign-extended immediate and illegal flag.
module decode_comb
   import decoder_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int EN_SYSTEM = 1
) (
   input  logic [31:0]     instr,
   output logic [2:0]      typ,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   instr_type_e        t;
   logic signed [31:0] imm32;

   // Classify the opcode and assemble the 32-bit immediate for that format.
   // Every format's bit 31 is instr[31], so widening imm32 as a signed value
   // gives the sign extension to XLEN for free (U-type included).
   always_comb begin
      t     = classify(instr[6:0], (XLEN == 64), (EN_SYSTEM != 0));
      imm32 = '0;
      case (t)
         TYPE_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
         TYPE_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         TYPE_B:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
         TYPE_U:  imm32 = {instr[31:12], 12'b0};
         TYPE_J:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign typ     = t;
   assign illegal = (t == TYPE_INV);
   assign imm     = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one output register plus a one-entry skid buffer
// holding raw {pc, instr}. in_ready depends only on skid occupancy, so there
// is no combinational path from out_ready back to fetch.
module decode_stage
   import decoder_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int PC_WIDTH  = 32,
   parameter int EN_SYSTEM = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [PC_WIDTH-1:0] in_pc,
   input  logic [31:0]         in_instr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PC_WIDTH-1:0] out_pc,
   output logic [6:0]          out_opcode,
   output logic [4:0]          out_rd,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic [2:0]          out_funct3,
   output logic [6:0]          out_funct7,
   output logic [XLEN-1:0]     out_imm,
   output logic [2:0]          out_type,
   output logic                out_illegal
);

   logic                skid_valid;
   logic [PC_WIDTH-1:0] skid_pc;
   logic [31:0]         skid_instr;

   logic                in_fire;
   logic                out_load;
   logic                load_data;
   logic [PC_WIDTH-1:0] sel_pc;
   logic [31:0]         sel_instr;

   logic [2:0]          dec_type;
   logic [XLEN-1:0]     dec_imm;
   logic                dec_illegal;

   // A word is only taken while the skid is free; flush discards the offer.
   assign in_ready = !skid_valid;
   assign in_fire  = in_valid && !skid_valid && !flush;

   // Output register may be (re)loaded when empty or being consumed.
   assign out_load  = !out_valid || out_ready;
   assign load_data = !flush && out_load && (skid_valid || in_fire);

   // The skid entry is older than anything on the input, so it wins.
   assign sel_pc    = skid_valid ? skid_pc    : in_pc;
   assign sel_instr = skid_valid ? skid_instr : in_instr;

   decode_comb #(
      .XLEN      (XLEN),
      .EN_SYSTEM (EN_SYSTEM)
   ) u_decode_comb (
      .instr   (sel_instr),
      .typ     (dec_type),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

   // Skid buffer: fills when a word is accepted while the output is stalled,
   // empties into the output register as soon as it drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_instr <= '0;
      end else if (flush) begin
         skid_valid <= 1'b0;
      end else if (out_load) begin
         skid_valid <= 1'b0;
      end else if (in_fire) begin
         skid_valid <= 1'b1;
         skid_pc    <= in_pc;
         skid_instr <= in_instr;
      end
   end

   // Output valid: refilled from skid or input whenever the register drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (out_load) begin
         out_valid <= skid_valid || in_fire;
      end
   end

   // Output bundle: raw fields plus decoded type/imm, held while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_pc      <= '0;
         out_opcode  <= '0;
         out_rd      <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_funct3  <= '0;
         out_funct7  <= '0;
         out_imm     <= '0;
         out_type    <= '0;
         out_illegal <= 1'b0;
      end else if (load_data) begin
         out_pc      <= sel_pc;
         out_opcode  <= sel_instr[6:0];
         out_rd      <= sel_instr[11:7];
         out_rs1     <= sel_instr[19:15];
         out_rs2     <= sel_instr[24:20];
         out_funct3  <= sel_instr[14:12];
         out_funct7  <= sel_instr[31:25];
         out_imm     <= dec_imm;
         out_type    <= dec_type;
         out_illegal <= dec_illegal;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: accepted words push hand-computed
// expectations; monitors pop and compare whenever a bundle is consumed.
module tb_decode_stage;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [2:0]  typ;
      logic [63:0] imm;
      logic        ill;
   } exp_t;

   logic clk;
   logic rst_n;

   // RV32, SYSTEM enabled
   logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0] in_pc, in_instr, out_pc, out_imm;
   logic [6:0]  out_opcode, out_funct7;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [2:0]  out_funct3, out_type;

   // RV64, SYSTEM disabled
   logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64, out_illegal64;
   logic [31:0] in_pc64, in_instr64, out_pc64;
   logic [63:0] out_imm64;
   logic [6:0]  out_opcode64, out_funct764;
   logic [4:0]  out_rd64, out_rs164, out_rs264;
   logic [2:0]  out_funct364, out_type64;

   exp_t q32[$];
   exp_t q64[$];
   exp_t cur32, cur64;
   exp_t vec32[8];
   exp_t vec64[5];

   int tests_run    = 0;
   int tests_failed = 0;

   decode_stage #(.XLEN(32), .PC_WIDTH(32), .EN_SYSTEM(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
      .out_type(out_type), .out_illegal(out_illegal)
   );

   decode_stage #(.XLEN(64), .PC_WIDTH(32), .EN_SYSTEM(0)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush64),
      .in_valid(in_valid64), .in_ready(in_ready64), .in_pc(in_pc64), .in_instr(in_instr64),
      .out_valid(out_valid64), .out_ready(out_ready64), .out_pc(out_pc64),
      .out_opcode(out_opcode64), .out_rd(out_rd64), .out_rs1(out_rs164), .out_rs2(out_rs264),
      .out_funct3(out_funct364), .out_funct7(out_funct764), .out_imm(out_imm64),
      .out_type(out_type64), .out_illegal(out_illegal64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer32(input exp_t e);
      in_valid = 1'b1;
      in_pc    = e.pc;
      in_instr = e.instr;
      cur32    = e;
   endtask

   task automatic offer64(input exp_t e);
      in_valid64 = 1'b1;
      in_pc64    = e.pc;
      in_instr64 = e.instr;
      cur64      = e;
   endtask

   task automatic drain32(input int budget);
      int n;
      n = 0;
      while (q32.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain32_pending", 128'(q32.size()), 128'(0));
      q32.delete();
   endtask

   task automatic drain64(input int budget);
      int n;
      n = 0;
      while (q64.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain64_pending", 128'(q64.size()), 128'(0));
      q64.delete();
   endtask

   // Record every accepted word; flush drops everything in flight.
   always @(posedge clk) begin
      if (rst_n) begin
         if (flush) q32.delete();
         else if (in_valid && in_ready) q32.push_back(cur32);
         if (flush64) q64.delete();
         else if (in_valid64 && in_ready64) q64.push_back(cur64);
      end
   end

   // Monitor for the RV32 instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (q32.size() == 0) begin
            chk("unexpected32_pc", 128'(out_pc), 128'hdead_0000);
         end else begin
            e = q32.pop_front();
            $display("[TB] dut32 pc=%08h opc=%07b type=%0d imm=%08h ill=%0d",
                     out_pc, out_opcode, out_type, out_imm, out_illegal);
            chk("bundle32",
                128'({out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                      out_type, out_illegal}),
                128'({e.pc, e.instr[6:0], e.instr[11:7], e.instr[19:15], e.instr[24:20],
                      e.instr[14:12], e.instr[31:25], e.typ, e.ill}));
            chk("imm32", 128'(out_imm), 128'(e.imm[31:0]));
         end
      end
   end

   // Monitor for the RV64 instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid64 && out_ready64) begin
         if (q64.size() == 0) begin
            chk("unexpected64_pc", 128'(out_pc64), 128'hdead_0000);
         end else begin
            e = q64.pop_front();
            $display("[TB] dut64 pc=%08h opc=%07b type=%0d imm=%016h ill=%0d",
                     out_pc64, out_opcode64, out_type64, out_imm64, out_illegal64);
            chk("bundle64",
                128'({out_pc64, out_opcode64, out_rd64, out_rs164, out_rs264, out_funct364,
                      out_funct764, out_type64, out_illegal64}),
                128'({e.pc, e.instr[6:0], e.instr[11:7], e.instr[19:15], e.instr[24:20],
                      e.instr[14:12], e.instr[31:25], e.typ, e.ill}));
            chk("imm64", 128'(out_imm64), 128'(e.imm));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // type / imm table (hand-derived)
      vec32[0] = '{32'h0000_0200, 32'h0080_00EF, 3'b101, 64'h8,                   1'b0}; // jal x1,8
      vec32[1] = '{32'h0000_0204, 32'h0031_00B3, 3'b000, 64'h0,                   1'b0}; // add
      vec32[2] = '{32'h0000_0208, 32'h0000_0073, 3'b001, 64'h0,                   1'b0}; // ecall
      vec32[3] = '{32'h0000_020C, 32'h0000_0000, 3'b111, 64'h0,                   1'b1}; // zero word
      vec32[4] = '{32'h0000_0210, 32'h0000_007F, 3'b111, 64'h0,                   1'b1}; // opc 1111111
      vec32[5] = '{32'h0000_0214, 32'h0010_009B, 3'b111, 64'h0,                   1'b1}; // addiw on RV32
      vec32[6] = '{32'h0000_0218, 32'h8000_02B7, 3'b100, 64'h8000_0000,           1'b0}; // lui neg
      vec32[7] = '{32'h0000_021C, 32'h0000_000F, 3'b001, 64'h0,                   1'b0}; // fence
      vec64[0] = '{32'h0000_0500, 32'h8000_02B7, 3'b100, 64'hFFFF_FFFF_8000_0000, 1'b0}; // lui
      vec64[1] = '{32'h0000_0504, 32'h0010_009B, 3'b001, 64'h1,                   1'b0}; // addiw
      vec64[2] = '{32'h0000_0508, 32'h0000_0073, 3'b111, 64'h0,                   1'b1}; // ecall, no SYSTEM
      vec64[3] = '{32'h0000_050C, 32'h0031_00BB, 3'b000, 64'h0,                   1'b0}; // addw
      vec64[4] = '{32'h0000_0510, 32'hFFF0_0093, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0}; // addi -1

      rst_n = 1'b0;   flush = 1'b0;   in_valid = 1'b0;   out_ready = 1'b1;
      in_pc = '0;     in_instr = '0;
      flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1;
      in_pc64 = '0;   in_instr64 = '0;

      // reset state
      #3;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_in_ready",  128'(in_ready),  128'(1));
      chk("rst_data",      128'({out_pc, out_imm, out_type, out_illegal}), 128'(0));
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      cyc();

      // single addi, one-cycle latency
      offer32('{32'h0000_0100, 32'hFFF0_0093, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("latency_valid", 128'(out_valid), 128'(1));
      chk("addi_rd_rs1",   128'({out_rd, out_rs1}), 128'({5'd1, 5'd0}));
      drain32(10);

      // back-to-back stream with out_ready held high: no bubbles
      offer32('{32'h0000_0104, 32'h0020_A423, 3'b010, 64'h8, 1'b0});
      cyc();
      offer32('{32'h0000_0108, 32'hFE00_0EE3, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
      @(negedge clk);
      chk("stream_valid0", 128'(out_valid), 128'(1));
      cyc();
      offer32('{32'h0000_010C, 32'h1234_52B7, 3'b100, 64'h1234_5000, 1'b0});
      @(negedge clk);
      chk("stream_valid1", 128'(out_valid), 128'(1));
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("stream_valid2", 128'(out_valid), 128'(1));
      drain32(10);

      // format / illegal table
      for (int i = 0; i < 8; i++) begin
         offer32(vec32[i]);
         cyc();
      end
      in_valid = 1'b0;
      drain32(20);

      // stall: three cycles of backpressure with input offered
      out_ready = 1'b0;
      offer32('{32'h0000_0300, 32'h0050_0113, 3'b001, 64'h5, 1'b0});
      @(negedge clk);
      chk("stall_ready_c1", 128'(in_ready), 128'(1));
      cyc();
      offer32('{32'h0000_0304, 32'h00A0_0193, 3'b001, 64'hA, 1'b0});
      @(negedge clk);
      chk("stall_ready_c2", 128'(in_ready), 128'(1));
      cyc();
      offer32('{32'h0000_0308, 32'h00F0_0213, 3'b001, 64'hF, 1'b0});
      @(negedge clk);
      chk("stall_ready_c3", 128'(in_ready), 128'(0));
      chk("stall_pc_c3",    128'(out_pc),   128'(32'h300));
      cyc();
      @(negedge clk);
      chk("stall_ready_c4", 128'(in_ready), 128'(0));
      chk("stall_hold_pc",  128'(out_pc),   128'(32'h300));
      chk("stall_hold_imm", 128'(out_imm),  128'(32'h5));
      cyc();
      out_ready = 1'b1;
      cyc();
      cyc();
      in_valid = 1'b0;
      drain32(10);

      // flush with output and skid both occupied
      out_ready = 1'b0;
      offer32('{32'h0000_0400, 32'h0031_00B3, 3'b000, 64'h0, 1'b0});
      cyc();
      offer32('{32'h0000_0404, 32'h0020_A423, 3'b010, 64'h8, 1'b0});
      cyc();
      offer32('{32'h0000_0408, 32'h1234_52B7, 3'b100, 64'h1234_5000, 1'b0});
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 128'(out_valid), 128'(0));
      chk("flush_in_ready",  128'(in_ready),  128'(1));
      cyc();
      out_ready = 1'b1;
      repeat (4) cyc();
      // input offered in a flush cycle with the stage empty is dropped
      offer32('{32'h0000_040C, 32'h0080_00EF, 3'b101, 64'h8, 1'b0});
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_drop_valid", 128'(out_valid), 128'(0));
      cyc();
      offer32('{32'h0000_0410, 32'hFFF0_0093, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      cyc();
      in_valid = 1'b0;
      drain32(10);

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      offer32('{32'h0000_0600, 32'h0050_0113, 3'b001, 64'h5, 1'b0});
      cyc();
      offer32('{32'h0000_0604, 32'h00A0_0193, 3'b001, 64'hA, 1'b0});
      cyc();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      q32.delete();
      #1;
      chk("amid_out_valid", 128'(out_valid), 128'(0));
      chk("amid_in_ready",  128'(in_ready),  128'(1));
      chk("amid_out_pc",    128'(out_pc),    128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      cyc();
      offer32('{32'h0000_0610, 32'h00F0_0213, 3'b001, 64'hF, 1'b0});
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("restart_pc", 128'(out_pc), 128'(32'h610));
      drain32(10);

      // RV64 instance, SYSTEM disabled
      for (int i = 0; i < 5; i++) begin
         offer64(vec64[i]);
         cyc();
      end
      in_valid64 = 1'b0;
      drain64(20);

      repeat (3) cyc();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
